hex_out_pio: RTL and testbench
==============================

Name: hex_out_pio

Overview:
- Avalon-MM slave output port that drives one 7-segment HEX display from the Nios II side of the dnn_accel_system.
- It is the write-side counterpart of the read-only input PIO slaves: the CPU writes a segment pattern and the block drives it onto out_port.
- Adds atomic set/clear access and a hardware blink timer, so software can flash a status digit without polling.

Parameters:
- DATA_WIDTH, 7, width of the data register and out_port (must be >= 4).
- RESET_VALUE, 7'h7F, data register value after reset (segments active-low, so all off).
- BLANK_VALUE, 7'h7F, pattern driven on out_port during the blink "off" phase.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  register word offset.
- chipselect  in  1  slave select; qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  DATA_WIDTH  segment drive to the HEX pins.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n = 0:
  - data = RESET_VALUE, ctrl = 0, period = 0, cnt = 0, phase = 0.
  - readdata = 0, out_port = RESET_VALUE (or the decoded value of RESET_VALUE[3:0] when HEX_DECODE_EN is defined).
- Write strobe: wr = chipselect & ~write_n, sampled on the rising edge of clk. Zero wait states.
- Register map (word offsets):
  - 0 DATA, R/W. A write loads writedata[DATA_WIDTH-1:0].
  - 1 CTRL, R/W. bit0 = blink_en; other bits read 0.
  - 2 PERIOD, R/W, 32 bits. Blink half-period in clk cycles, minus 1.
  - 3 reserved. Reads 0; writes are ignored.
  - 4 OUTSET, write-only. data <= data | writedata[DATA_WIDTH-1:0]. Reads 0.
  - 5 OUTCLEAR, write-only. data <= data & ~writedata[DATA_WIDTH-1:0]. Reads 0.
  - 6, 7: read 0; writes are ignored.
- Read path: readdata is registered every clk, independent of chipselect.
  - readdata = zero-extended register selected by address, giving 1-cycle read latency.
  - A read in the same cycle as a write to the same address returns the pre-write value.
- Blink counter:
  - Active when ctrl.blink_en = 1 and period != 0.
  - Each clk: if cnt == period, then cnt <= 0 and phase <= ~phase; else cnt <= cnt + 1.
  - When inactive, cnt <= 0 and phase <= 0 every cycle.
- Restart rules:
  - A write to PERIOD or CTRL forces cnt <= 0 and phase <= 0 in that cycle. This overrides the terminal-count toggle.
  - A write to DATA, OUTSET or OUTCLEAR does not disturb cnt or phase.
- Output: out_port is a register, updated 1 clk after the data, phase or ctrl change.
  - out_port = BLANK_VALUE when the counter is active and phase = 1.
  - Otherwise out_port = seg(data).
  - seg() is the identity function unless HEX_DECODE_EN is defined.
- Write-to-pin latency: data changes on the write edge, and out_port reflects it on the next edge.
- Counter wrap: the 32-bit cnt never wraps, because it resets at period. period = 32'hFFFFFFFF is legal.
- Reset mid-blink: state returns to the reset values immediately (asynchronous assertion). Release is synchronous to clk.

Optional Feature:
- Macro: HEX_DECODE_EN.
- When defined: seg(data) = active-low 7-segment decode of data[3:0], bit order gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - data[DATA_WIDTH-1:4] is ignored for output.
  - DATA readback still returns the raw register.
- When undefined: out_port carries the raw data bits; no decoder is synthesised.

Test Plan:
- Reset value: assert reset_n = 0 mid-cycle → out_port = 7F and readdata = 0 immediately. After release, read addr0 → 0000007F on the next edge.
- DATA write/readback: write addr0 = 32'hFFFFFF40 → out_port = 40 one cycle later. Read addr0 → 00000040.
- OUTSET/OUTCLEAR: from data = 40, write addr4 = 01 → data = 41; then write addr5 = 40 → data = 01. Reads of addr4 and addr5 return 0.
- Blink waveform: data = 40, PERIOD = 2, CTRL = 1.
  - out_port alternates 40 / 7F with each level lasting 3 cycles.
  - Rewriting PERIOD mid-"off" phase restores 40 on the next edge and restarts the 3-cycle count.
- Blink disabled or period 0: CTRL = 1 with PERIOD = 0 → out_port stays 40 and cnt stays 0. Writing CTRL = 0 during phase = 1 → out_port returns to 40 the next cycle.
- HEX_DECODE_EN build: write addr0 = 0xA → out_port = 08. Write addr0 = 0x1F → out_port = 0E, and readback returns 0000001F.

Source files
------------

// File: rtl/hex_out_pio_if.sv
// hex_out_pio_if: Avalon-MM slave bus bundle for hex_out_pio.
//   address    - register word offset (3 bits)
//   chipselect - slave select, qualifies writes
//   write_n    - active-low write strobe
//   writedata  - 32-bit write data
//   readdata   - 32-bit registered read data (driven by the slave)
interface hex_out_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hex_out_pio.sv
// hex_out_pio: Avalon-MM output PIO driving one 7-segment HEX display, with
// atomic set/clear access and a hardware blink timer.
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - hex_out_pio_if.slave (address, chipselect, write_n,
//              writedata, readdata; zero wait states, 1-cycle read latency)
//   out_port - registered segment drive (DATA_WIDTH bits)
// Register map: 0 DATA, 1 CTRL (bit0 blink_en), 2 PERIOD (half-period - 1),
//   3 reserved, 4 OUTSET, 5 OUTCLEAR, 6-7 unused.
// Optional build macro HEX_DECODE_EN: out_port becomes the active-low
//   gfedcba decode of data[3:0] instead of the raw data bits.
module hex_out_pio #(
  parameter int unsigned           DATA_WIDTH  = 7,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 7'h7F,
  parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = 7'h7F
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hex_out_pio_if.slave          bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_CTRL     = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_RSVD     = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLEAR = 3'd5
  } reg_addr_e;

`ifdef HEX_DECODE_EN
  function automatic logic [DATA_WIDTH-1:0] seg(input logic [3:0] nib);
    logic [6:0]  p;
    logic [31:0] w;
    p = '1;
    case (nib)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
      default: p = '1;
    endcase
    // Segments beyond gfedcba (wide DATA_WIDTH) are held off.
    w = {25'h1FF_FFFF, p};
    return w[DATA_WIDTH-1:0];
  endfunction
  localparam logic [DATA_WIDTH-1:0] RESET_SEG = seg(RESET_VALUE[3:0]);
`else
  localparam logic [DATA_WIDTH-1:0] RESET_SEG = RESET_VALUE;
`endif

  logic [DATA_WIDTH-1:0] data;
  logic                  ctrl;
  logic [31:0]           period;
  logic [31:0]           cnt;
  logic                  phase;

  logic                  wr;
  logic                  restart;
  logic                  active;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] seg_now;
  logic [31:0]           rd_next;
  logic                  unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = &{1'b0, bus.writedata};
  assign active    = ctrl & (period != '0);
  assign restart   = wr & ((bus.address == REG_CTRL) | (bus.address == REG_PERIOD));

`ifdef HEX_DECODE_EN
  assign seg_now = seg(data[3:0]);
`else
  assign seg_now = data;
`endif

  always_comb begin
    rd_next = '0;
    case (bus.address)
      REG_DATA:   rd_next = 32'(data);
      REG_CTRL:   rd_next = {31'd0, ctrl};
      REG_PERIOD: rd_next = period;
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data         <= RESET_VALUE;
      ctrl         <= 1'b0;
      period       <= '0;
      cnt          <= '0;
      phase        <= 1'b0;
      bus.readdata <= '0;
      out_port     <= RESET_SEG;
    end else begin
      if (wr) begin
        case (bus.address)
          REG_DATA:     data   <= wd;
          REG_CTRL:     ctrl   <= bus.writedata[0];
          REG_PERIOD:   period <= bus.writedata;
          REG_OUTSET:   data   <= data | wd;
          REG_OUTCLEAR: data   <= data & ~wd;
          default:      ;
        endcase
      end

      // A CTRL/PERIOD write wins over the terminal-count toggle.
      if (restart || !active) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == period) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt   <= cnt + 32'd1;
      end

      out_port     <= (active && phase) ? BLANK_VALUE : seg_now;
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_hex_out_pio.sv
module tb_hex_out_pio;

  logic       clk;
  logic       reset_n;
  logic [6:0] out_port;

  hex_out_pio_if bus();

  hex_out_pio #(
    .DATA_WIDTH (7),
    .RESET_VALUE(7'h7F),
    .BLANK_VALUE(7'h7F)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the number of cycles the
  // blink timer has been running since it last (re)started.
  logic [6:0]  m_data;
  logic        m_ctrl;
  logic [31:0] m_period;
  longint unsigned m_t;

  function automatic logic [6:0] ref_seg(input logic [6:0] d);
`ifdef HEX_DECODE_EN
    case (d[3:0])
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
`else
    return d;
`endif
  endfunction

  function automatic bit m_active();
    return m_ctrl && (m_period != 0);
  endfunction

  // Off phase = odd-numbered half-period since the timer started.
  function automatic bit m_blank();
    longint unsigned half;
    if (!m_active()) return 1'b0;
    half = longint'(m_period) + 1;
    return ((m_t / half) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_data   = 7'h7F;
    m_ctrl   = 1'b0;
    m_period = '0;
    m_t      = 0;
  endtask

  task automatic do_cycle(input logic cs, input logic wn, input logic [2:0] a,
                          input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic [6:0]  exp_out;
    bit          wr;
    @(negedge clk);
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    @(posedge clk);
    #1;
    case (a)
      3'd0:    exp_rd = {25'd0, m_data};
      3'd1:    exp_rd = {31'd0, m_ctrl};
      3'd2:    exp_rd = m_period;
      default: exp_rd = 32'd0;
    endcase
    exp_out = m_blank() ? 7'h7F : ref_seg(m_data);
    check("readdata", bus.readdata, exp_rd);
    check("out_port", {25'd0, out_port}, {25'd0, exp_out});

    wr = cs && !wn;
    if (wr && (a == 3'd1 || a == 3'd2)) m_t = 0;
    else if (m_active())                m_t = m_t + 1;
    else                                m_t = 0;
    if (wr) begin
      case (a)
        3'd0: m_data   = wd[6:0];
        3'd1: m_ctrl   = wd[0];
        3'd2: m_period = wd;
        3'd4: m_data   = m_data | wd[6:0];
        3'd5: m_data   = m_data & ~wd[6:0];
        default: ;
      endcase
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    do_cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) do_cycle(1'b0, 1'b1, a, $urandom);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_port", {25'd0, out_port}, {25'd0, ref_seg(7'h7F)});
    check("rst_readdata", bus.readdata, 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] wd;
    reset_n        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = '0;
    model_reset();
    #12;
    check("rst_out_port", {25'd0, out_port}, {25'd0, ref_seg(7'h7F)});
    check("rst_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;

    idle(3'd0, 2);
    check("rst_data_rb", bus.readdata, 32'h0000_007F);

    // DATA write/readback, OUTSET/OUTCLEAR
    wr_reg(3'd0, 32'hFFFF_FF40);
    idle(3'd0, 2);
    wr_reg(3'd4, 32'h01);
    idle(3'd0, 1);
    check("outset_rb", bus.readdata, 32'h41);
    wr_reg(3'd5, 32'h40);
    idle(3'd4, 1);
    idle(3'd5, 1);
    idle(3'd0, 1);
    check("outclear_rb", bus.readdata, 32'h01);

    // Blink with PERIOD = 2; rewrite PERIOD mid-off phase
    wr_reg(3'd0, 32'h40);
    wr_reg(3'd2, 32'd2);
    wr_reg(3'd1, 32'd1);
    idle(3'd2, 10);
    wr_reg(3'd2, 32'd2);
    idle(3'd1, 8);

    // PERIOD = 0 keeps the display steady; CTRL = 0 during the off phase
    wr_reg(3'd2, 32'd0);
    idle(3'd0, 5);
    wr_reg(3'd2, 32'd2);
    idle(3'd0, 4);
    wr_reg(3'd1, 32'd0);
    idle(3'd0, 3);

    // Maximum period is legal
    wr_reg(3'd2, 32'hFFFF_FFFF);
    wr_reg(3'd1, 32'd1);
    idle(3'd2, 5);
    wr_reg(3'd1, 32'd0);

    // Decoder patterns (raw pass-through in the default build)
    wr_reg(3'd0, 32'h0A);
    idle(3'd0, 1);
    wr_reg(3'd0, 32'h1F);
    idle(3'd0, 2);
    check("raw_rb_1f", bus.readdata, 32'h1F);

    // Randomized traffic, with one asynchronous reset in the middle
    for (int unsigned i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 15) begin
        case (a)
          3'd2: wd = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4));
          default: wd = $urandom;
        endcase
        do_cycle(1'b1, 1'b0, a, wd);
      end else begin
        do_cycle(1'($urandom_range(0, 1)), 1'b1, a, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
